// File: rtl/tone_generator.sv
// tone_generator: chatter-filtered square-wave speaker driver with boundary-aligned note changes (optional TONE_VOLUME_EN adds VOLUME PWM gating)
module tone_generator #(
    parameter int WIDTH         = 29,
    parameter int STABLE_CYCLES = 100000,
    parameter int MIN_HALF      = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] frequency,
`ifdef TONE_VOLUME_EN
    input  logic [2:0]       VOLUME,
`endif
    output logic             SPEAKER,
    output logic             PLAYING,
    output logic             NOTE_START,
    output logic             NOTE_CHANGE
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0] STAB = SW'(STABLE_CYCLES);
    localparam logic [WIDTH-1:0] MINH = WIDTH'(MIN_HALF);
    typedef enum logic {IDLE, PLAY} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] cand, qual, period_q, period_n, cnt, cnt_n;
    logic [SW-1:0] scnt, scnt_n;
    logic sq, sq_n, start_n, change_n, qual_valid, boundary;
    assign qual_valid = qual >= MINH;
    assign boundary = cnt == period_q - WIDTH'(1);
    // run length of the current input value, counting the edge that first sees it
    always_comb scnt_n = (frequency != cand) ? SW'(1) : (scnt < STAB) ? scnt + SW'(1) : scnt;
    // chatter filter: accept a value on the edge that completes its stable run
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cand <= '0;
            scnt <= '0;
            qual <= '0;
        end else begin
            cand <= frequency;
            scnt <= scnt_n;
            if (scnt_n == STAB) qual <= frequency;
        end
    end
    // next state: start, retune or stop only at half-period boundaries
    always_comb begin
        state_n  = state;
        period_n = period_q;
        cnt_n    = cnt;
        sq_n     = sq;
        start_n  = 1'b0;
        change_n = 1'b0;
        if (state == IDLE) begin
            cnt_n = '0;
            sq_n  = 1'b0;
            if (qual_valid) begin
                period_n = qual;
                sq_n     = 1'b1;
                start_n  = 1'b1;
                state_n  = PLAY;
            end
        end else if (boundary) begin
            cnt_n    = '0;
            sq_n     = qual_valid ? ~sq : 1'b0;
            state_n  = qual_valid ? PLAY : IDLE;
            change_n = qual_valid && (qual != period_q);
            period_n = change_n ? qual : period_q;
        end else begin
            cnt_n = cnt + WIDTH'(1);
        end
    end
    // state and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            period_q    <= '0;
            cnt         <= '0;
            sq          <= 1'b0;
            PLAYING     <= 1'b0;
            NOTE_START  <= 1'b0;
            NOTE_CHANGE <= 1'b0;
        end else begin
            state       <= state_n;
            period_q    <= period_n;
            cnt         <= cnt_n;
            sq          <= sq_n;
            PLAYING     <= state_n == PLAY;
            NOTE_START  <= start_n;
            NOTE_CHANGE <= change_n;
        end
    end
`ifdef TONE_VOLUME_EN
    logic [2:0] pwm;
    // free-running duty counter for volume gating
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) pwm <= '0;
        else pwm <= pwm + 3'd1;
    end
    assign SPEAKER = sq & ({1'b0, pwm} < ({1'b0, VOLUME} + 4'd1));
`else
    assign SPEAKER = sq;
`endif
endmodule

// File: tb/tb_tone_generator.sv
// tb_tone_generator: randomized and directed checks of tone_generator against a cycle-level behavioural model
module tb_tone_generator;
    localparam int W = 29, SC = 4, MH = 2;
    logic CLK = 1'b0, RST = 1'b1;
    logic [W-1:0] frequency = '0;
    logic SPEAKER, PLAYING, NOTE_START, NOTE_CHANGE;
`ifdef TONE_VOLUME_EN
    logic [2:0] VOLUME = 3'd7;
`endif
    int errors = 0, checks = 0;
    int m_last, m_run, m_qual, m_half, m_left, m_pwm;
    bit m_play, m_sq, m_start, m_chg;

    tone_generator #(.WIDTH(W), .STABLE_CYCLES(SC), .MIN_HALF(MH)) dut (
        .CLK(CLK),
        .RST(RST),
        .frequency(frequency),
`ifdef TONE_VOLUME_EN
        .VOLUME(VOLUME),
`endif
        .SPEAKER(SPEAKER),
        .PLAYING(PLAYING),
        .NOTE_START(NOTE_START),
        .NOTE_CHANGE(NOTE_CHANGE)
    );

    always #5 CLK = ~CLK;

    task automatic m_reset();
        m_last = 0; m_run = 0; m_qual = 0; m_half = 0; m_left = 0; m_pwm = 0;
        m_play = 0; m_sq = 0; m_start = 0; m_chg = 0;
    endtask

    // one clock edge of the model; f is the input seen at that edge
    task automatic m_edge(input int f);
        m_start = 0;
        m_chg = 0;
        m_pwm = (m_pwm + 1) % 8;
        if (!m_play) begin
            if (m_qual >= MH) begin
                m_play = 1; m_half = m_qual; m_left = m_qual; m_sq = 1; m_start = 1;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                if (m_qual >= MH) begin
                    m_sq = !m_sq;
                    if (m_qual != m_half) begin m_half = m_qual; m_chg = 1; end
                    m_left = m_half;
                end else begin
                    m_play = 0; m_sq = 0;
                end
            end
        end
        if (f != m_last) begin m_last = f; m_run = 1; end
        else if (m_run < SC) m_run++;
        if (m_run == SC) m_qual = f;
    endtask

    function automatic logic [3:0] exp_outs();
        logic spk;
`ifdef TONE_VOLUME_EN
        spk = m_sq && (m_pwm <= int'(VOLUME));
`else
        spk = m_sq;
`endif
        return {spk, m_play, m_start, m_chg};
    endfunction

    task automatic step();
        @(posedge CLK);
        m_edge(int'(frequency));
        @(negedge CLK);
    endtask

    task automatic test_reset();
        frequency = 10;
        m_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if ({SPEAKER, PLAYING} !== 2'b00) begin
                errors++; $display("FAIL reset_hold got=%b want=00", {SPEAKER, PLAYING});
            end
        end
        RST = 0;
        for (int i = 1; i <= 5; i++) begin
            step();
            checks++;
            if ({SPEAKER, PLAYING, NOTE_START, NOTE_CHANGE} !== exp_outs()) begin
                errors++; $display("FAIL reset_run edge=%0d got=%b want=%b", i, {SPEAKER, PLAYING, NOTE_START, NOTE_CHANGE}, exp_outs());
            end
            checks++;
            if ({SPEAKER, NOTE_START} !== ((i == 5) ? 2'b11 : 2'b00)) begin
                errors++; $display("FAIL note_start_edge edge=%0d got=%b want=%b", i, {SPEAKER, NOTE_START}, (i == 5) ? 2'b11 : 2'b00);
            end
        end
    endtask

    task automatic test_steady();
        logic prev = SPEAKER;
        int len = 1;
        bit seen = 0;
        frequency = 10;
        for (int i = 0; i < 70; i++) begin
            step();
            checks++;
            if ({SPEAKER, PLAYING, NOTE_START, NOTE_CHANGE} !== exp_outs()) begin
                errors++; $display("FAIL steady cyc=%0d got=%b want=%b", i, {SPEAKER, PLAYING, NOTE_START, NOTE_CHANGE}, exp_outs());
            end
            if (SPEAKER !== prev) begin
                if (seen) begin
                    checks++;
                    if (len != 10) begin errors++; $display("FAIL steady_half got=%0d want=10", len); end
                end
                seen = 1; len = 1; prev = SPEAKER;
            end else len++;
        end
    endtask

    task automatic test_chatter();
        int chg = 0;
        frequency = 6;
        for (int i = 0; i < 43; i++) begin
            if (i == 3) frequency = 10;
            step();
            chg += NOTE_CHANGE;
            checks++;
            if ({SPEAKER, PLAYING, NOTE_START, NOTE_CHANGE} !== exp_outs()) begin
                errors++; $display("FAIL chatter cyc=%0d got=%b want=%b", i, {SPEAKER, PLAYING, NOTE_START, NOTE_CHANGE}, exp_outs());
            end
        end
        checks++;
        if (chg != 0) begin errors++; $display("FAIL chatter_changes got=%0d want=0", chg); end
    endtask

    task automatic test_note_change();
        int chg = 0, len = 1;
        logic prev;
        repeat ($urandom_range(1, 9)) step();
        frequency = 6;
        prev = SPEAKER;
        for (int i = 0; i < 60; i++) begin
            step();
            chg += NOTE_CHANGE;
            checks++;
            if ({SPEAKER, PLAYING, NOTE_START, NOTE_CHANGE} !== exp_outs()) begin
                errors++; $display("FAIL note_change cyc=%0d got=%b want=%b", i, {SPEAKER, PLAYING, NOTE_START, NOTE_CHANGE}, exp_outs());
            end
            if (SPEAKER !== prev) begin len = 1; prev = SPEAKER; end else len++;
        end
        checks++;
        if (chg != 1) begin errors++; $display("FAIL note_change_pulses got=%0d want=1", chg); end
        checks++;
        if (NOTE_START !== 1'b0 && NOTE_CHANGE !== 1'b0) begin errors++; $display("FAIL pulse_overlap got=11 want=not both"); end
    endtask

    task automatic test_silence();
        int n = 0;
        while (SPEAKER !== 1'b1 && n < 20) begin step(); n++; end
        checks++;
        if (SPEAKER !== 1'b1) begin errors++; $display("FAIL silence_wait_high got=%b want=1", SPEAKER); end
        step();
        frequency = 0;
        n = 0;
        while (PLAYING === 1'b1 && n < 40) begin
            step(); n++;
            checks++;
            if ({SPEAKER, PLAYING, NOTE_START, NOTE_CHANGE} !== exp_outs()) begin
                errors++; $display("FAIL silence cyc=%0d got=%b want=%b", n, {SPEAKER, PLAYING, NOTE_START, NOTE_CHANGE}, exp_outs());
            end
        end
        checks++;
        if ({SPEAKER, PLAYING} !== 2'b00) begin errors++; $display("FAIL silence_timeout got=%b want=00", {SPEAKER, PLAYING}); end
        frequency = 8;
        repeat (15) step();
        frequency = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            checks++;
            if ({SPEAKER, PLAYING, NOTE_START, NOTE_CHANGE} !== exp_outs()) begin
                errors++; $display("FAIL silence_one cyc=%0d got=%b want=%b", i, {SPEAKER, PLAYING, NOTE_START, NOTE_CHANGE}, exp_outs());
            end
        end
        checks++;
        if (PLAYING !== 1'b0) begin errors++; $display("FAIL silence_one_end got=%b want=0", PLAYING); end
    endtask

    task automatic test_async_reset();
        int n = 0;
        frequency = 8;
        while (SPEAKER !== 1'b1 && n < 30) begin step(); n++; end
        checks++;
        if (SPEAKER !== 1'b1) begin errors++; $display("FAIL areset_wait got=%b want=1", SPEAKER); end
        #2 RST = 1;
        #1;
        checks++;
        if ({SPEAKER, PLAYING} !== 2'b00) begin errors++; $display("FAIL areset_immediate got=%b want=00", {SPEAKER, PLAYING}); end
        m_reset();
        @(negedge CLK);
        RST = 0;
    endtask

`ifdef TONE_VOLUME_EN
    task automatic test_volume();
        int hi = 0;
        VOLUME = 1;
        frequency = 200;
        repeat (12) step();
        for (int i = 0; i < 64; i++) begin
            step();
            hi += SPEAKER;
            checks++;
            if ({SPEAKER, PLAYING, NOTE_START, NOTE_CHANGE} !== exp_outs()) begin
                errors++; $display("FAIL volume cyc=%0d got=%b want=%b", i, {SPEAKER, PLAYING, NOTE_START, NOTE_CHANGE}, exp_outs());
            end
        end
        checks++;
        if (hi != 16) begin errors++; $display("FAIL volume_duty got=%0d want=16", hi); end
        VOLUME = 7;
    endtask
`endif

    task automatic test_random();
        for (int s = 0; s < 40; s++) begin
            frequency = W'($urandom_range(0, 12));
`ifdef TONE_VOLUME_EN
            VOLUME = 3'($urandom_range(0, 7));
`endif
            for (int i = 0, n = $urandom_range(1, 25); i < n; i++) begin
                step();
                checks++;
                if ({SPEAKER, PLAYING, NOTE_START, NOTE_CHANGE} !== exp_outs()) begin
                    errors++; $display("FAIL random seg=%0d cyc=%0d f=%0d got=%b want=%b", s, i, frequency, {SPEAKER, PLAYING, NOTE_START, NOTE_CHANGE}, exp_outs());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_chatter();
        test_note_change();
        test_silence();
        test_async_reset();
`ifdef TONE_VOLUME_EN
        test_volume();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tone_generator.md
Name: tone_generator

Overview:
- Downstream of the button-to-note stage. Consumes its `frequency` word, a half-period count in CLK cycles where 0 means silence, and drives the speaker square wave.
- Qualifies the incoming count against chatter.
- Applies note changes only at half-period boundaries, so every half-period completes in full.
- Flags playback status to the scoring/display logic.

Parameters:
- WIDTH, 29, width of the frequency/half-period word.
- STABLE_CYCLES, 100000, consecutive cycles an input value must hold before acceptance (1 ms at 100 MHz). Minimum 1.
- MIN_HALF, 2, half-period counts below this are treated as silence.

Ports:
- CLK  in  1  system clock, 100 MHz.
- RST  in  1  reset, asynchronous, active-high.
- frequency  in  WIDTH  requested half-period in CLK cycles; 0 means silence.
- SPEAKER  out  1  square-wave audio output.
- PLAYING  out  1  high while in the PLAY state.
- NOTE_START  out  1  one-cycle pulse on entry to PLAY from IDLE.
- NOTE_CHANGE  out  1  one-cycle pulse when a new period is loaded while already in PLAY.

Behaviour:
- Reset (async, RST=1):
  - state=IDLE; SPEAKER=0, PLAYING=0, NOTE_START=0, NOTE_CHANGE=0.
  - cand=0, scnt=0, qual=0, period_q=0, cnt=0.
  - Reset mid-note silences the output immediately.
- Stability filter (runs in every state):
  - If frequency != cand: cand<=frequency, scnt<=1.
  - Else if scnt < STABLE_CYCLES: scnt<=scnt+1.
  - When scnt==STABLE_CYCLES-1 and frequency==cand: qual<=cand on that edge.
  - Net effect: a value held constant for STABLE_CYCLES edges appears on qual at the edge ending that run.
  - STABLE_CYCLES=1 means qual follows frequency with 1 cycle delay.
  - A glitch resets the run; qual keeps its old value.
- Definition: qual_valid = (qual >= MIN_HALF).
- IDLE:
  - SPEAKER=0, cnt=0.
  - If qual_valid: period_q<=qual, cnt<=0, SPEAKER<=1, NOTE_START pulses for 1 cycle, go to PLAY.
- PLAY:
  - cnt increments each cycle.
  - Half-period boundary is cnt==period_q-1. At the boundary, cnt<=0 and one of the following applies:
    - qual_valid and qual==period_q: SPEAKER toggles.
    - qual_valid and qual!=period_q: SPEAKER toggles, period_q<=qual, NOTE_CHANGE pulses for 1 cycle.
    - not qual_valid: SPEAKER<=0, go to IDLE. Silence therefore lands at the end of a full half-period; no truncated high pulse.
  - Away from the boundary, qual changes have no effect.
- PLAYING = (state==PLAY), registered.
- NOTE_START and NOTE_CHANGE are never high in the same cycle.
- Width rules:
  - cnt and period_q are WIDTH bits.
  - No wrap: period_q >= MIN_HALF >= 2 and cnt resets at period_q-1.
- Output frequency = 100e6 / (2*period_q) Hz; e.g. 191112 gives 261.6 Hz.

Optional Feature:
- Macro: TONE_VOLUME_EN.
- Defined:
  - Adds input port VOLUME, in, 3 bits.
  - A free-running 3-bit pwm counter increments every cycle and resets to 0 on RST.
  - SPEAKER = sq & (pwm < VOLUME+1), where sq is the internal square wave. VOLUME=7 gives full amplitude; VOLUME=0 gives a 1/8 duty.
  - PLAYING, NOTE_START and NOTE_CHANGE are unaffected.
- Undefined: no VOLUME port; SPEAKER = sq.

Test Plan (STABLE_CYCLES=4, MIN_HALF=2 unless noted):
- Reset: RST=1 with frequency=10 -> SPEAKER=0, PLAYING=0; after release, SPEAKER=1 and NOTE_START=1 on the 5th edge after frequency=10 has been held.
- Steady tone: frequency=10 held -> SPEAKER toggles every 10 cycles; period 20 cycles; NOTE_CHANGE stays 0.
- Note change: frequency 10 then 6 mid-half-period -> old half-period completes 10 cycles; NOTE_CHANGE pulses once; subsequent half-periods are 6 cycles.
- Chatter: frequency=6 held for 3 cycles, then back to 10 -> no NOTE_CHANGE; period stays 10.
- Silence: frequency=0 while SPEAKER=1 mid-half-period -> SPEAKER stays 1 until the boundary, then 0; PLAYING falls the same edge; no partial pulse. frequency=1 also yields silence.
- Async reset mid-note: assert RST between edges while SPEAKER=1 -> SPEAKER=0 immediately, before the next CLK edge.
- TONE_VOLUME_EN with VOLUME=1: during SPEAKER-high phases, output is high for 2 of every 8 cycles.
